// File: rtl/enc_8x3_hs.sv
// enc_8x3_hs: sequential 8-to-3 priority encoder with a valid/ready output.
// Request lines are captured into a sticky pending register; the winning
// pending index is presented as a 3-bit code and its pending bit is cleared
// when the consumer accepts it. Encode-side partner of the 3-to-8 decoders.

module enc_8x3_hs #(
  parameter int EDGE_MODE = 0,
  parameter int HIGH_PRIO = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [2:0] code_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic [7:0] pend_o,
  output logic       multi_o
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] pend;
  logic [7:0] pend_nxt;
  logic [7:0] req_q;
  logic [7:0] set_bits;
  logic [7:0] clr_bits;
  logic [2:0] prio_idx;
  logic [2:0] code_nxt;
  logic       valid_nxt;
  logic       accept;
  logic       multi_nxt;
  logic [3:0] pend_cnt;

  assign accept = valid_o & ready_i;
  assign pend_o = pend;

  // Capture: either every high request line, or only its 0->1 transitions.
  always_comb begin
    set_bits = req;
    if (EDGE_MODE != 0) begin
      set_bits = req & ~req_q;
    end
  end

  // Served bit is cleared only in the accept cycle; a same-cycle set re-pends it.
  always_comb begin
    clr_bits = 8'd0;
    if (accept) begin
      clr_bits = 8'd1 << code_o;
    end
    pend_nxt = (pend & ~clr_bits) | set_bits;
  end

  // Count next-state pending bits so multi_o tracks the register it describes.
  always_comb begin
    pend_cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      pend_cnt = pend_cnt + {3'd0, pend_nxt[i]};
    end
    multi_nxt = (pend_cnt >= 4'd2);
  end

  // Priority pick from the registered pending vector; later loop hits win.
  always_comb begin
    prio_idx = 3'd0;
    if (HIGH_PRIO != 0) begin
      for (int i = 0; i < 8; i++) begin
        if (pend[i]) begin
          prio_idx = 3'(i);
        end
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (pend[i]) begin
          prio_idx = 3'(i);
        end
      end
    end
  end

  // Next-state logic: present a new code from IDLE, hold it until accepted.
  always_comb begin
    state_nxt = state;
    code_nxt  = code_o;
    valid_nxt = valid_o;
    case (state)
      IDLE: begin
        if (en && (pend != 8'd0)) begin
          code_nxt  = prio_idx;
          valid_nxt = 1'b1;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (ready_i) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Request history, pending register and its multi-bit flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= 8'd0;
      pend    <= 8'd0;
      multi_o <= 1'b0;
    end else begin
      req_q   <= req;
      pend    <= pend_nxt;
      multi_o <= multi_nxt;
    end
  end

  // Handshake state register and the registered code/valid outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      code_o  <= 3'd0;
      valid_o <= 1'b0;
    end else begin
      state   <= state_nxt;
      code_o  <= code_nxt;
      valid_o <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_enc_8x3_hs.sv
// tb_enc_8x3_hs: drives four parameter variants of enc_8x3_hs with shared
// inputs and checks each against a set-of-pending-requests model through a
// code scoreboard plus per-cycle pending/multi/valid comparisons.

module tb_enc_8x3_hs;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic       ready_i;

  logic [2:0] code  [4];
  logic       valid [4];
  logic [7:0] pend  [4];
  logic       multi [4];

  // Model state per variant: index c -> EDGE_MODE = c%2, HIGH_PRIO = c/2.
  logic [7:0] mPend [4];
  logic [7:0] mPrev [4];
  logic       mBusy [4];
  logic [2:0] mCode [4];
  logic       mMulti[4];
  logic [2:0] expQ  [4][$];

  int checks;
  int failures;

  for (genvar g = 0; g < 4; g++) begin : cfg
    enc_8x3_hs #(
      .EDGE_MODE(g % 2),
      .HIGH_PRIO(g / 2)
    ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .req    (req),
      .code_o (code[g]),
      .valid_o(valid[g]),
      .ready_i(ready_i),
      .pend_o (pend[g]),
      .multi_o(multi[g])
    );
  end

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int c,
                             input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s cfg=%0d got=%h expected=%h t=%0t", name, c, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] pickWinner(input logic [7:0] p, input int hp);
    if (hp != 0) begin
      for (int i = 7; i >= 0; i--) if (p[i]) return 3'(i);
    end else begin
      for (int i = 0; i < 8; i++) if (p[i]) return 3'(i);
    end
    return 3'd0;
  endfunction

  task automatic modelClear();
    for (int c = 0; c < 4; c++) begin
      mPend[c] = 8'd0;
      mPrev[c] = 8'd0;
      mBusy[c] = 1'b0;
      mCode[c] = 3'd0;
      mMulti[c] = 1'b0;
      expQ[c].delete();
    end
  endtask

  // One clock of the behavioural model, using the inputs in force at the edge.
  task automatic modelStep(input int c);
    logic [7:0] newBits;
    logic [7:0] nextPend;
    logic       accepted;
    int         em;
    int         hp;
    em = c % 2;
    hp = c / 2;
    accepted = mBusy[c] && ready_i;
    for (int i = 0; i < 8; i++) begin
      if (em != 0) newBits[i] = req[i] && !mPrev[c][i];
      else         newBits[i] = req[i];
    end
    for (int i = 0; i < 8; i++) begin
      nextPend[i] = (mPend[c][i] && !(accepted && (int'(mCode[c]) == i))) || newBits[i];
    end
    if (!mBusy[c] && en && (mPend[c] != 8'd0)) begin
      mCode[c] = pickWinner(mPend[c], hp);
      mBusy[c] = 1'b1;
      expQ[c].push_back(mCode[c]);
    end else if (accepted) begin
      mBusy[c] = 1'b0;
    end
    mPrev[c]  = req;
    mPend[c]  = nextPend;
    mMulti[c] = ($countones(nextPend) >= 2);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      for (int c = 0; c < 4; c++) modelStep(c);
    end
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic e, input logic [7:0] r, input logic rdy, input int n);
    for (int k = 0; k < n; k++) begin
      en      = e;
      req     = r;
      ready_i = rdy;
      tick();
    end
  endtask

  // Monitor: pops the expected code when a presentation starts and compares
  // per-cycle state against the model.
  initial begin
    logic       prevValid[4];
    logic [2:0] prevCode [4];
    logic [2:0] want;
    for (int c = 0; c < 4; c++) begin
      prevValid[c] = 1'b0;
      prevCode[c]  = 3'd0;
    end
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int c = 0; c < 4; c++) prevValid[c] = 1'b0;
      end else begin
        for (int c = 0; c < 4; c++) begin
          checkOutput("valid", c, 8'(valid[c]), 8'(mBusy[c]));
          checkOutput("pend", c, pend[c], mPend[c]);
          checkOutput("multi", c, 8'(multi[c]), 8'(mMulti[c]));
          if (valid[c] === 1'b1 && !prevValid[c]) begin
            if (expQ[c].size() == 0) begin
              checks++;
              failures++;
              $display("[TB] FAIL unexpected_code cfg=%0d got=%0d expected=none t=%0t", c, code[c], $time);
            end else begin
              want = expQ[c].pop_front();
              checkOutput("code", c, 8'(code[c]), 8'(want));
            end
          end else if (valid[c] === 1'b1 && prevValid[c]) begin
            checkOutput("code_hold", c, 8'(code[c]), 8'(prevCode[c]));
          end
          prevValid[c] = (valid[c] === 1'b1);
          prevCode[c]  = code[c];
        end
      end
    end
  end

  // Stimulus: reset, directed scenarios, random traffic, mid-handshake reset.
  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    req      = 8'd0;
    ready_i  = 1'b0;
    modelClear();
    #3;
    for (int c = 0; c < 4; c++) begin
      checkOutput("rst_valid", c, 8'(valid[c]), 8'd0);
      checkOutput("rst_pend", c, pend[c], 8'd0);
      checkOutput("rst_code", c, 8'(code[c]), 8'd0);
      checkOutput("rst_multi", c, 8'(multi[c]), 8'd0);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;

    $display("[TB] single request");
    applyStimulus(1'b1, 8'h10, 1'b1, 1);
    applyStimulus(1'b1, 8'h00, 1'b1, 1);
    for (int c = 0; c < 4; c++) begin
      checkOutput("single_valid", c, 8'(valid[c]), 8'd1);
      checkOutput("single_code", c, 8'(code[c]), 8'd4);
    end
    applyStimulus(1'b1, 8'h00, 1'b1, 1);
    for (int c = 0; c < 4; c++) begin
      checkOutput("single_pend_clr", c, pend[c], 8'd0);
      checkOutput("single_valid_clr", c, 8'(valid[c]), 8'd0);
    end
    applyStimulus(1'b1, 8'h00, 1'b1, 2);

    $display("[TB] priority order");
    applyStimulus(1'b1, 8'h81, 1'b1, 1);
    applyStimulus(1'b1, 8'h00, 1'b1, 7);

    $display("[TB] backpressure");
    applyStimulus(1'b1, 8'h08, 1'b0, 1);
    applyStimulus(1'b1, 8'h00, 1'b0, 2);
    applyStimulus(1'b1, 8'h40, 1'b0, 1);
    applyStimulus(1'b1, 8'h00, 1'b0, 4);
    for (int c = 0; c < 4; c++) checkOutput("bp_code", c, 8'(code[c]), 8'd3);
    applyStimulus(1'b1, 8'h00, 1'b1, 6);

    $display("[TB] set/clear collision");
    applyStimulus(1'b1, 8'h04, 1'b1, 8);
    applyStimulus(1'b1, 8'h00, 1'b1, 6);

    $display("[TB] enable gating");
    applyStimulus(1'b0, 8'h0C, 1'b1, 1);
    applyStimulus(1'b0, 8'h00, 1'b1, 3);
    for (int c = 0; c < 4; c++) begin
      checkOutput("gate_pend", c, pend[c], 8'h0C);
      checkOutput("gate_multi", c, 8'(multi[c]), 8'd1);
      checkOutput("gate_valid", c, 8'(valid[c]), 8'd0);
    end
    applyStimulus(1'b1, 8'h00, 1'b1, 6);

    $display("[TB] random traffic");
    for (int k = 0; k < 600; k++) begin
      applyStimulus(($urandom % 8) != 0, 8'($urandom & $urandom), ($urandom % 3) != 0, 1);
    end
    applyStimulus(1'b1, 8'h00, 1'b1, 24);

    $display("[TB] reset mid-handshake");
    applyStimulus(1'b1, 8'hA5, 1'b0, 4);
    for (int c = 0; c < 4; c++) begin
      checkOutput("pre_rst_valid", c, 8'(valid[c]), 8'd1);
      checkOutput("pre_rst_pend", c, pend[c], 8'hA5);
    end
    #2 rst_n = 1'b0;
    modelClear();
    #1;
    for (int c = 0; c < 4; c++) begin
      checkOutput("mid_rst_valid", c, 8'(valid[c]), 8'd0);
      checkOutput("mid_rst_pend", c, pend[c], 8'd0);
      checkOutput("mid_rst_code", c, 8'(code[c]), 8'd0);
      checkOutput("mid_rst_multi", c, 8'(multi[c]), 8'd0);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    applyStimulus(1'b1, 8'h00, 1'b1, 4);

    for (int c = 0; c < 4; c++) checkOutput("queue_empty", c, 8'(expQ[c].size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
